// File: rtl/counter_load_ctrl.sv
// Load sequencer for a 4-bit async-load up counter: queues reload requests, issues one-cycle load pulses.
// Latency: request accepted at edge N -> load_value at N+1, load high N+2..N+3, result checked at N+4.
// Backpressure: req_ready drops while the FIFO is full; one load is issued per 4 cycles.
//
// Ports:
//   clk, rst_n            clock shared with the counter, async active-low reset
//   req_valid/req_value   reload request handshake in, req_ready out
//   count_in              counter output fed back for wrap detection and load checking
//   load, load_value      registered drive for the counter's load and Input pins
//   fifo_level, busy      queued entries, FSM-not-idle status
//   wrap_seen, load_err   15->0 wrap pulse, sticky load-check failure

// Generic single-clock FIFO; head is presented combinationally on pop_dat.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of 2, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module counter_load_ctrl #(
  parameter int DEPTH       = 4,
  parameter int AUTO_RELOAD = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [3:0]             req_value,
  output logic                   req_ready,
  input  logic [3:0]             count_in,
  output logic                   load,
  output logic [3:0]             load_value,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   wrap_seen,
  output logic                   load_err
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t     state_q, state_d;
  logic       load_d;
  logic [3:0] load_value_d;
  logic [3:0] last_value, last_value_d;
  logic       load_err_d;
  logic [3:0] prev_count;
  logic       wrap_now;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] fifo_head;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  // Queued requests win over auto-reload: popping is decided before the wrap path.
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign wrap_now  = (prev_count == 4'hF) && (count_in == 4'h0);
  assign busy      = (state_q != IDLE);

  sync_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (req_value),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    load_d       = 1'b0;
    load_value_d = load_value;
    last_value_d = last_value;
    load_err_d   = load_err;
    unique case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          load_value_d = fifo_head;
          last_value_d = fifo_head;
          state_d      = SETUP;
        end else if ((AUTO_RELOAD != 0) && wrap_now) begin
          load_value_d = last_value;
          state_d      = SETUP;
        end
      end
      // load_value has now been stable a full cycle before load rises.
      SETUP: begin
        load_d  = 1'b1;
        state_d = PULSE;
      end
      PULSE: state_d = HOLD;
      // load was still high at the previous edge, so the counter must show load_value here.
      HOLD: begin
        if (count_in != load_value) load_err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset lands in SETUP so the first edge after release loads 0 into the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETUP;
      load       <= 1'b0;
      load_value <= 4'h0;
      last_value <= 4'h0;
      prev_count <= 4'h0;
      wrap_seen  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load       <= load_d;
      load_value <= load_value_d;
      last_value <= last_value_d;
      prev_count <= count_in;
      wrap_seen  <= wrap_now;
      load_err   <= load_err_d;
    end
  end
endmodule

// File: tb/tb_counter_load_ctrl.sv
// Directed bench for counter_load_ctrl with an async-load up counter model in the loop.
// A second instance with auto-reload disabled covers the wrap-without-reload case.
module tb_counter_load_ctrl;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid, req_ready;
  logic [3:0] req_value;
  logic [3:0] count_in;
  logic       load;
  logic [3:0] load_value;
  logic [2:0] fifo_level;
  logic       busy, wrap_seen, load_err;

  logic       req_valid0, req_ready0;
  logic [3:0] req_value0;
  logic [3:0] count_in0;
  logic       load0;
  logic [3:0] load_value0;
  logic [2:0] fifo_level0;
  logic       busy0, wrap_seen0, load_err0;

  logic       force_en;
  logic [3:0] force_val;
  logic [3:0] cnt, cnt0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [3:0] log_val [$];
  int         log_cyc [$];
  logic [3:0] burst_vals [5] = '{4'd3, 4'd7, 4'd12, 4'd5, 4'd1};
  logic       rdy;
  int         guard;

  counter_load_ctrl #(.DEPTH(4), .AUTO_RELOAD(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .count_in(count_in), .load(load), .load_value(load_value),
    .fifo_level(fifo_level), .busy(busy), .wrap_seen(wrap_seen), .load_err(load_err)
  );

  counter_load_ctrl #(.DEPTH(4), .AUTO_RELOAD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_value(req_value0),
    .req_ready(req_ready0), .count_in(count_in0), .load(load0), .load_value(load_value0),
    .fifo_level(fifo_level0), .busy(busy0), .wrap_seen(wrap_seen0), .load_err(load_err0)
  );

  // Counter: load is level-sensitive and overrides counting.
  always @(posedge clk or posedge load) begin
    if (load) cnt <= load_value;
    else      cnt <= cnt + 4'd1;
  end
  always @(posedge clk or posedge load0) begin
    if (load0) cnt0 <= load_value0;
    else       cnt0 <= cnt0 + 4'd1;
  end
  assign count_in  = force_en ? force_val : cnt;
  assign count_in0 = cnt0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (load) begin
      log_val.push_back(load_value);
      log_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_value = 4'd0;
    req_valid0 = 1'b0; req_value0 = 4'd0; force_en = 1'b0; force_val = 4'd0;
    tick; tick; tick;

    // Reset state
    chk("rst_load", int'(load), 0);
    chk("rst_load_value", int'(load_value), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_wrap", int'(wrap_seen), 0);
    chk("rst_err", int'(load_err), 0);

    // Release at R: load 0 at R+1, idle at R+3
    rst_n = 1'b1;
    tick;
    chk("r1_load", int'(load), 1);
    chk("r1_load_value", int'(load_value), 0);
    chk("r1_busy", int'(busy), 1);
    tick;
    chk("r2_load", int'(load), 0);
    chk("r2_count", int'(count_in), 0);
    chk("r2_busy", int'(busy), 1);
    tick;
    chk("r3_busy", int'(busy), 0);
    chk("r3_err", int'(load_err), 0);
    chk("r3_count", int'(count_in), 1);
    chk("r3_load", int'(load), 0);
    chk("r3_busy0", int'(busy0), 0);

    // Single request 9, accepted at N
    chk("n0_ready", int'(req_ready), 1);
    req_valid = 1'b1; req_value = 4'd9;
    tick;
    req_valid = 1'b0;
    chk("n_level", int'(fifo_level), 1);
    chk("n_busy", int'(busy), 0);
    chk("n_load", int'(load), 0);
    tick;
    chk("n1_level", int'(fifo_level), 0);
    chk("n1_busy", int'(busy), 1);
    chk("n1_load_value", int'(load_value), 9);
    chk("n1_load", int'(load), 0);
    tick;
    chk("n2_load", int'(load), 1);
    chk("n2_load_value", int'(load_value), 9);
    tick;
    chk("n3_load", int'(load), 0);
    chk("n3_count", int'(count_in), 9);
    chk("n3_load_value", int'(load_value), 9);
    tick;
    chk("n4_busy", int'(busy), 0);
    chk("n4_count", int'(count_in), 10);
    chk("n4_err", int'(load_err), 0);

    // Burst 3,7,12,5,1: FIFO fills to DEPTH, loads come out in order 4 cycles apart
    log_val.delete(); log_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_value = burst_vals[i];
      guard = 0;
      do begin
        rdy = req_ready;
        tick;
        guard++;
      end while (!rdy && guard < 20);
    end
    req_valid = 1'b0;
    chk("burst_level_full", int'(fifo_level), 4);
    chk("burst_ready_low", int'(req_ready), 0);
    guard = 0;
    while (log_val.size() < 5 && guard < 40) begin tick; guard++; end
    chk("burst_count", log_val.size(), 5);
    if (log_val.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("burst_val", int'(log_val[i]), int'(burst_vals[i]));
      for (int i = 1; i < 5; i++) chk("burst_gap", log_cyc[i] - log_cyc[i-1], 4);
    end
    guard = 0;
    while (busy && guard < 10) begin tick; guard++; end
    chk("burst_idle", int'(busy), 0);
    chk("burst_level_empty", int'(fifo_level), 0);
    chk("burst_err", int'(load_err), 0);

    // Request 14 to both instances at P; wrap at P+7
    req_valid = 1'b1; req_value = 4'd14;
    req_valid0 = 1'b1; req_value0 = 4'd14;
    tick;
    req_valid = 1'b0; req_valid0 = 1'b0;
    tick; tick; tick; tick; tick;
    chk("p6_count", int'(count_in), 0);
    chk("p6_wrap", int'(wrap_seen), 0);
    chk("p6_busy", int'(busy), 0);
    tick;
    chk("p7_wrap", int'(wrap_seen), 1);
    chk("p7_busy", int'(busy), 1);
    chk("p7_load_value", int'(load_value), 14);
    chk("p7_wrap0", int'(wrap_seen0), 1);
    chk("p7_busy0", int'(busy0), 0);
    tick;
    chk("p8_load", int'(load), 1);
    chk("p8_wrap", int'(wrap_seen), 0);
    chk("p8_count", int'(count_in), 14);
    chk("p8_load0", int'(load0), 0);
    chk("p8_count0", int'(count_in0), 2);
    tick;
    chk("p9_load", int'(load), 0);
    tick;
    chk("p10_busy", int'(busy), 0);
    chk("p10_count", int'(count_in), 15);

    // Request 2 queued just before the next wrap: 2 wins, reload of 14 dropped
    req_valid = 1'b1; req_value = 4'd2;
    tick;
    req_valid = 1'b0;
    chk("p11_level", int'(fifo_level), 1);
    chk("p11_count", int'(count_in), 0);
    chk("p11_busy", int'(busy), 0);
    tick;
    chk("p12_wrap", int'(wrap_seen), 1);
    chk("p12_load_value", int'(load_value), 2);
    chk("p12_level", int'(fifo_level), 0);
    tick;
    chk("p13_load", int'(load), 1);
    tick;
    chk("p14_count", int'(count_in), 2);
    tick;
    chk("p15_busy", int'(busy), 0);
    chk("p15_count", int'(count_in), 3);
    chk("p15_err", int'(load_err), 0);

    // Wrong counter value during HOLD sets the sticky error
    req_valid = 1'b1; req_value = 4'd8;
    tick;
    req_valid = 1'b0;
    tick; tick;
    chk("q3_load", int'(load), 1);
    tick;
    chk("q4_count", int'(count_in), 8);
    force_en = 1'b1; force_val = 4'd5;
    tick;
    force_en = 1'b0;
    chk("q5_err", int'(load_err), 1);
    chk("q5_busy", int'(busy), 0);
    tick; tick;
    chk("q7_err_sticky", int'(load_err), 1);

    // Reset asserted while load is high
    req_valid = 1'b1; req_value = 4'd6;
    tick;
    req_value = 4'd4;
    tick;
    req_valid = 1'b0;
    tick;
    chk("s3_load", int'(load), 1);
    chk("s3_load_value", int'(load_value), 6);
    chk("s3_level", int'(fifo_level), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_load", int'(load), 0);
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_err", int'(load_err), 0);
    chk("mid_rst_load_value", int'(load_value), 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("rr1_load", int'(load), 1);
    chk("rr1_load_value", int'(load_value), 0);
    tick; tick;
    chk("rr3_busy", int'(busy), 0);
    chk("rr3_err", int'(load_err), 0);
    chk("rr3_count", int'(count_in), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
